// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master, round-robin arbiter for a shared, wait-stated slave bus.
// Master 0 is the CPU and master 1 is the DMA engine. A granted transaction
// runs through the states IDLE -> ADDR -> (WAIT)* -> ACK -> IDLE. The bus
// direction, address and write data are held constant from ADDR through ACK.
// The number of WAIT cycles comes from the region select that the external
// decoder raises from Bus_Addr. If no select or more than one select is
// raised, the access ends with an error acknowledge and no wait states.
//
// Ports
//   Clk, Reset_L           clock and asynchronous active-low reset
//   Mn_Req_H               level request from master n (n = 0 CPU, 1 DMA)
//   Mn_Addr/WData/Write_H  master n address, write data and direction
//   Mn_Ack_H               one-cycle completion pulse to master n
//   Mn_Err_H, Mn_RData     error flag and read data, valid only with Mn_Ack_H
//   Bus_Addr/WData/Write_H registered address, data and direction to the bus
//   Bus_Strobe_H           registered strobe, high during ADDR and WAIT
//   Bus_RData              read data returned by the selected slave
//   *_Select_H             region selects decoded externally from Bus_Addr
//   Grant_H                one-hot bus owner; bit n = master n
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ROM_WS = 1,  // ROM wait states, 0-15
  parameter int RAM_WS = 2,  // RAM wait states, 0-15
  parameter int IO_WS  = 1,  // IO wait states, 0-15
  parameter int GFX_WS = 3   // graphics wait states, 0-15
) (
  input  logic        Clk,
  input  logic        Reset_L,

  input  logic        M0_Req_H,
  input  logic [31:0] M0_Addr,
  input  logic        M0_Write_H,
  input  logic [31:0] M0_WData,
  output logic        M0_Ack_H,
  output logic        M0_Err_H,
  output logic [31:0] M0_RData,

  input  logic        M1_Req_H,
  input  logic [31:0] M1_Addr,
  input  logic        M1_Write_H,
  input  logic [31:0] M1_WData,
  output logic        M1_Ack_H,
  output logic        M1_Err_H,
  output logic [31:0] M1_RData,

  output logic [31:0] Bus_Addr,
  output logic [31:0] Bus_WData,
  output logic        Bus_Write_H,
  output logic        Bus_Strobe_H,
  input  logic [31:0] Bus_RData,

  input  logic        ROM_Select_H,
  input  logic        RAM_Select_H,
  input  logic        IO_Select_H,
  input  logic        Graphics_Select_H,

  output logic [1:0]  Grant_H
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, ACK} state_t;

  localparam logic [3:0] ROM_W = 4'(ROM_WS);
  localparam logic [3:0] RAM_W = 4'(RAM_WS);
  localparam logic [3:0] IO_W  = 4'(IO_WS);
  localparam logic [3:0] GFX_W = 4'(GFX_WS);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;      // 1 = master 1 was granted last
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        strobe_q, strobe_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  sel;
  logic        pick1;
  logic [3:0]  region_ws;

  assign sel = {ROM_Select_H, RAM_Select_H, IO_Select_H, Graphics_Select_H};

  // Master 1 wins when it is the only requester, or when both request and
  // master 0 was served last.
  assign pick1 = M1_Req_H && (!M0_Req_H || !last_q);

  always_comb begin
    region_ws = 4'd0;
    unique case (1'b1)
      ROM_Select_H:      region_ws = ROM_W;
      RAM_Select_H:      region_ws = RAM_W;
      IO_Select_H:       region_ws = IO_W;
      Graphics_Select_H: region_ws = GFX_W;
      default:           region_ws = 4'd0;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (M0_Req_H || M1_Req_H) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          addr_d  = pick1 ? M1_Addr    : M0_Addr;
          wdata_d = pick1 ? M1_WData   : M0_WData;
          write_d = pick1 ? M1_Write_H : M0_Write_H;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = ADDR;
        end
      end

      ADDR: begin
        if ($onehot(sel)) begin
          cnt_d = region_ws;
          err_d = 1'b0;
          if (region_ws != 4'd0) begin
            state_d = WAIT;
          end else begin
            rdata_d = write_q ? '0 : Bus_RData;
            state_d = ACK;
          end
        end else begin
          // Unmapped or ambiguous decode: acknowledge with error at once.
          cnt_d   = 4'd0;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ACK;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          rdata_d = write_q ? '0 : Bus_RData;
          state_d = ACK;
        end
      end

      ACK: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    strobe_d = (state_d == ADDR) || (state_d == WAIT);
  end

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;   // master 0 wins the first tie
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      strobe_q <= 1'b0;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign Bus_Addr     = addr_q;
  assign Bus_WData    = wdata_q;
  assign Bus_Write_H  = write_q;
  assign Bus_Strobe_H = strobe_q;
  assign Grant_H      = grant_q;

  // Acknowledge and its qualifiers are decoded from registers only, and the
  // non-granted master sees zeros.
  assign M0_Ack_H = (state_q == ACK) && grant_q[0];
  assign M1_Ack_H = (state_q == ACK) && grant_q[1];
  assign M0_Err_H = M0_Ack_H && err_q;
  assign M1_Err_H = M1_Ack_H && err_q;
  assign M0_RData = M0_Ack_H ? rdata_q : '0;
  assign M1_RData = M1_Ack_H ? rdata_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed testbench for bus_arbiter. The ROM region is built with zero wait
// states and the other regions keep their default wait states. A small address
// decoder drives the region selects from Bus_Addr:
//   0x00xxxxxx ROM, 0x04xxxxxx graphics, 0x06xxxxxx IO, 0x08xxxxxx RAM,
//   anything else is unmapped.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_L;
  logic        M0_Req_H, M0_Write_H, M1_Req_H, M1_Write_H;
  logic [31:0] M0_Addr, M0_WData, M1_Addr, M1_WData;
  logic        M0_Ack_H, M0_Err_H, M1_Ack_H, M1_Err_H;
  logic [31:0] M0_RData, M1_RData;
  logic [31:0] Bus_Addr, Bus_WData, Bus_RData;
  logic        Bus_Write_H, Bus_Strobe_H;
  logic        ROM_Select_H, RAM_Select_H, IO_Select_H, Graphics_Select_H;
  logic [1:0]  Grant_H;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  assign ROM_Select_H      = (Bus_Addr[31:24] == 8'h00);
  assign Graphics_Select_H = (Bus_Addr[31:24] == 8'h04);
  assign IO_Select_H       = (Bus_Addr[31:24] == 8'h06);
  assign RAM_Select_H      = (Bus_Addr[31:24] == 8'h08);

  bus_arbiter #(.ROM_WS(0), .RAM_WS(2), .IO_WS(1), .GFX_WS(3)) dut (
    .Clk(Clk), .Reset_L(Reset_L),
    .M0_Req_H(M0_Req_H), .M0_Addr(M0_Addr), .M0_Write_H(M0_Write_H),
    .M0_WData(M0_WData), .M0_Ack_H(M0_Ack_H), .M0_Err_H(M0_Err_H),
    .M0_RData(M0_RData),
    .M1_Req_H(M1_Req_H), .M1_Addr(M1_Addr), .M1_Write_H(M1_Write_H),
    .M1_WData(M1_WData), .M1_Ack_H(M1_Ack_H), .M1_Err_H(M1_Err_H),
    .M1_RData(M1_RData),
    .Bus_Addr(Bus_Addr), .Bus_WData(Bus_WData), .Bus_Write_H(Bus_Write_H),
    .Bus_Strobe_H(Bus_Strobe_H), .Bus_RData(Bus_RData),
    .ROM_Select_H(ROM_Select_H), .RAM_Select_H(RAM_Select_H),
    .IO_Select_H(IO_Select_H), .Graphics_Select_H(Graphics_Select_H),
    .Grant_H(Grant_H)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue one transaction from master m, drop the request after it is
  // granted, and check strobe, acknowledge timing and the returned values.
  // edges = number of rising edges from ADDR entry to the ACK cycle (1 + WS).
  task automatic run_txn(input string tag, input int m, input logic [31:0] addr,
                         input logic wr, input logic [31:0] wdata,
                         input int edges, input logic exp_err,
                         input logic [31:0] exp_rdata);
    logic ack, err, oack;
    logic [31:0] rdata;
    if (m == 0) begin
      M0_Req_H = 1'b1; M0_Addr = addr; M0_Write_H = wr; M0_WData = wdata;
    end else begin
      M1_Req_H = 1'b1; M1_Addr = addr; M1_Write_H = wr; M1_WData = wdata;
    end
    step();
    check({tag, " grant"}, 32'(Grant_H), (m == 0) ? 32'd1 : 32'd2);
    check({tag, " addr"}, Bus_Addr, addr);
    check({tag, " strobe@addr"}, 32'(Bus_Strobe_H), 32'd1);
    // The request is withdrawn and the inputs scrambled mid-transaction.
    M0_Req_H = 1'b0; M1_Req_H = 1'b0;
    M0_Addr = 32'hFFFF_FFFF; M1_Addr = 32'hFFFF_FFFF;
    M0_WData = 32'h0; M1_WData = 32'h0;
    for (int k = 1; k <= edges; k++) begin
      step();
      ack   = (m == 0) ? M0_Ack_H : M1_Ack_H;
      oack  = (m == 0) ? M1_Ack_H : M0_Ack_H;
      err   = (m == 0) ? M0_Err_H : M1_Err_H;
      rdata = (m == 0) ? M0_RData : M1_RData;
      check({tag, " ack"}, 32'(ack), (k == edges) ? 32'd1 : 32'd0);
      check({tag, " strobe"}, 32'(Bus_Strobe_H), (k < edges) ? 32'd1 : 32'd0);
      check({tag, " wdata hold"}, Bus_WData, wdata);
      check({tag, " write hold"}, 32'(Bus_Write_H), 32'(wr));
      if (k == edges) begin
        check({tag, " err"}, 32'(err), 32'(exp_err));
        if (!wr) check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " other ack"}, 32'(oack), 32'd0);
      end
    end
    step();
    check({tag, " ack drop"}, 32'({M0_Ack_H, M1_Ack_H}), 32'd0);
    check({tag, " grant clear"}, 32'(Grant_H), 32'd0);
  endtask

  initial begin
    logic saw_ack;
    int   ack_cnt;

    M0_Req_H = 0; M0_Addr = 0; M0_Write_H = 0; M0_WData = 0;
    M1_Req_H = 0; M1_Addr = 0; M1_Write_H = 0; M1_WData = 0;
    Bus_RData = 32'hDEAD_BEEF;
    Reset_L = 1'b0;
    #1;
    check("reset grant", 32'(Grant_H), 32'd0);
    check("reset strobe", 32'(Bus_Strobe_H), 32'd0);
    check("reset acks", 32'({M0_Ack_H, M1_Ack_H, M0_Err_H, M1_Err_H}), 32'd0);
    check("reset bus addr", Bus_Addr, 32'd0);
    step(); step();
    Reset_L = 1'b1;
    step();

    // RAM read, two wait states: ACK three edges after the granting edge.
    run_txn("ram read", 0, 32'h0800_0010, 1'b0, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);

    // Graphics write from the DMA master, three wait states.
    run_txn("gfx write", 1, 32'h0401_0004, 1'b1, 32'h1234_5678, 4, 1'b0, 32'h0);

    // Unmapped read: error acknowledge, no wait states, read data forced to 0.
    run_txn("unmapped", 0, 32'h0200_0000, 1'b0, 32'h0, 1, 1'b1, 32'h0);

    // Reset pulsed while a RAM read sits in WAIT.
    M0_Req_H = 1'b1; M0_Addr = 32'h0800_0010; M0_Write_H = 1'b0;
    step();
    M0_Req_H = 1'b0;
    step();
    check("pre-reset strobe", 32'(Bus_Strobe_H), 32'd1);
    #2 Reset_L = 1'b0;
    #1;
    check("async reset grant", 32'(Grant_H), 32'd0);
    check("async reset strobe", 32'(Bus_Strobe_H), 32'd0);
    check("async reset addr", Bus_Addr, 32'd0);
    #3 Reset_L = 1'b1;
    saw_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (M0_Ack_H || M1_Ack_H) saw_ack = 1'b1;
    end
    check("no ack after reset", 32'(saw_ack), 32'd0);

    // Both masters request RAM reads continuously: grants alternate from M0.
    M0_Req_H = 1'b1; M0_Addr = 32'h0800_0000; M0_Write_H = 1'b0;
    M1_Req_H = 1'b1; M1_Addr = 32'h0800_0004; M1_Write_H = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rr grant %0d", i), 32'(Grant_H),
            (i % 2 == 0) ? 32'd1 : 32'd2);
      for (int k = 0; k < 4; k++) begin
        step();
        check("rr grant onehot", 32'($onehot0(Grant_H)), 32'd1);
      end
    end
    M0_Req_H = 1'b0; M1_Req_H = 1'b0;
    // Drain any transaction that started on the edge after the last loop.
    for (int k = 0; k < 6; k++) step();
    check("rr drained", 32'(Grant_H), 32'd0);

    // Zero-wait ROM read with the request held: ACK every third cycle.
    M0_Req_H = 1'b1; M0_Addr = 32'h0000_0000; M0_Write_H = 1'b0;
    Bus_RData = 32'h0BAD_F00D;
    step();
    ack_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("rom b2b ack %0d", k), 32'(M0_Ack_H),
            (k % 3 == 1) ? 32'd1 : 32'd0);
      if (M0_Ack_H) ack_cnt++;
      if (k % 3 == 1) check("rom b2b rdata", M0_RData, 32'h0BAD_F00D);
      check("rom b2b m1 ack", 32'(M1_Ack_H), 32'd0);
    end
    check("rom b2b ack count", 32'(ack_cnt), 32'd3);
    M0_Req_H = 1'b0;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
